// File: rtl/uart_cmd_parser.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Frames UART bytes into START/CMD/LEN/payload/CHK commands with
//            XOR checksum, length bound and inter-byte timeout checking.
//            Optional PARSER_STATS_EN adds good/bad frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0] START_BYTE  = 8'h24,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic        iCLK,
    input  logic        RST_n,
    input  logic [7:0]  rxd,
    input  logic        RECEIVE_END,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [7:0]  cmd_len,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int              c_TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TMO     = c_TW'(TIMEOUT_CYC);
    localparam logic [c_TW-1:0] c_TMO_ONE = c_TW'(1);
    localparam logic [7:0]      c_MAX_LEN = 8'(MAX_LEN);
    localparam logic [4:0]      c_BUF_N   = 5'(MAX_LEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic            r_rx_end_q;
    logic            w_stb;
    logic            w_tmo_exp;
    logic [2:0]      r_state;
    logic [c_TW-1:0] r_tmo;
    logic [7:0]      r_cmd_tmp;
    logic [7:0]      r_len_tmp;
    logic [7:0]      r_chk;
    logic [3:0]      r_idx;
    logic [7:0]      r_buf [0:15];
    logic            r_cmd_valid;
    logic            r_frame_err;
    logic [7:0]      r_cmd;
    logic [7:0]      r_cmd_len;
    logic [1:0]      r_err_code;

    // A level-high RECEIVE_END produces one strobe on its rising edge only.
    assign w_stb     = RECEIVE_END & ~r_rx_end_q;
    assign w_tmo_exp = (r_state != S_IDLE) && (r_tmo == c_TMO) && !w_stb;

    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rx_end_q  <= 1'b0;
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_cmd_tmp   <= 8'h00;
            r_len_tmp   <= 8'h00;
            r_chk       <= 8'h00;
            r_idx       <= 4'd0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd       <= 8'h00;
            r_cmd_len   <= 8'h00;
            r_err_code  <= 2'd0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_rx_end_q  <= RECEIVE_END;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;

            if ((r_state == S_IDLE) || w_stb) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end

            if (w_tmo_exp) begin
                r_frame_err <= 1'b1;
                r_err_code  <= 2'd3;
                r_state     <= S_IDLE;
            end else if (w_stb) begin
                case (r_state)
                    S_IDLE: begin
                        if (rxd == START_BYTE) begin
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        r_cmd_tmp <= rxd;
                        r_chk     <= rxd;
                        r_state   <= S_LEN;
                    end
                    S_LEN: begin
                        if (rxd > c_MAX_LEN) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'd2;
                            r_state     <= S_IDLE;
                        end else begin
                            r_len_tmp <= rxd;
                            r_chk     <= r_chk ^ rxd;
                            r_idx     <= 4'd0;
                            r_state   <= (rxd == 8'h00) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        // Payload lands in place; no double buffering.
                        r_buf[r_idx] <= rxd;
                        r_chk        <= r_chk ^ rxd;
                        r_idx        <= r_idx + 4'd1;
                        if ({4'd0, r_idx} == (r_len_tmp - 8'd1)) begin
                            r_state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rxd == r_chk) begin
                            r_cmd       <= r_cmd_tmp;
                            r_cmd_len   <= r_len_tmp;
                            r_err_code  <= 2'd0;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'd1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_data   = ({1'b0, rd_addr} < c_BUF_N) ? r_buf[rd_addr] : 8'h00;
    assign cmd_valid = r_cmd_valid;
    assign frame_err = r_frame_err;
    assign cmd       = r_cmd;
    assign cmd_len   = r_cmd_len;
    assign err_code  = r_err_code;
    assign busy      = (r_state != S_IDLE);

`ifdef PARSER_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            r_good_cnt <= 16'h0000;
            r_bad_cnt  <= 16'h0000;
        end else begin
            if (r_cmd_valid && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (r_frame_err && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Table-driven, hand-written and randomized checks of
//            uart_cmd_parser against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int         T     = 40;
    localparam int         MAXL  = 8;
    localparam logic [7:0] START = 8'h24;

    logic       iCLK;
    logic       RST_n;
    logic [7:0] rxd;
    logic       RECEIVE_END;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic [7:0] cmd_len;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef PARSER_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    uart_cmd_parser #(
        .START_BYTE  (START),
        .MAX_LEN     (MAXL),
        .TIMEOUT_CYC (T)
    ) dut (
        .iCLK        (iCLK),
        .RST_n       (RST_n),
        .rxd         (rxd),
        .RECEIVE_END (RECEIVE_END),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_len     (cmd_len),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
`ifdef PARSER_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
`endif
    );

    initial iCLK = 1'b0;
    always #50 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int ecnt     = 0;
    int since    = 0;

    // Reference model: collected frame bytes plus expected observable state.
    bit         m_active;
    logic [7:0] m_q [$];
    logic [7:0] m_buf [16];
    logic [7:0] m_cmd;
    logic [7:0] m_len;
    logic [1:0] m_code;
    int         m_vcnt, m_ecnt, m_good, m_bad;

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        int              hold;
        int              dv;
        int              de;
        logic [1:0]      code;
        logic [7:0]      cmd;
        logic [7:0]      len;
    } vec_t;
    vec_t vecs [5];

    always @(negedge iCLK) begin
        if (cmd_valid) vcnt++;
        if (frame_err) ecnt++;
    end

    task automatic chk(input string tag, input string name,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_q.delete();
        for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
        m_cmd  = 8'h00;
        m_len  = 8'h00;
        m_code = 2'd0;
        m_good = 0;
        m_bad  = 0;
    endfunction

    function automatic void model_err(input logic [1:0] c);
        m_code   = c;
        m_ecnt++;
        if (m_bad < 65535) m_bad++;
        m_active = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int         n;
        logic [7:0] x;
        if (!m_active) begin
            if (b == START) begin
                m_active = 1'b1;
                m_q.delete();
            end
        end else begin
            m_q.push_back(b);
            n = m_q.size();
            if (n == 2 && b > MAXL) begin
                model_err(2'd2);
            end else if (n >= 3 && n <= int'(m_q[1]) + 2) begin
                m_buf[n-3] = b;
            end else if (n >= 2 && n == int'(m_q[1]) + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
                if (x == b) begin
                    m_cmd    = m_q[0];
                    m_len    = m_q[1];
                    m_code   = 2'd0;
                    m_vcnt++;
                    if (m_good < 65535) m_good++;
                    m_active = 1'b0;
                end else begin
                    model_err(2'd1);
                end
            end
        end
    endfunction

    // One clock of elapsed time; a frame left idle past the limit times out.
    task automatic tick();
        @(negedge iCLK);
        since++;
        if (m_active && since == T + 2) model_err(2'd3);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int low);
        rxd         = b;
        RECEIVE_END = 1'b1;
        since       = 0;
        model_byte(b);
        repeat (hold) tick();
        RECEIVE_END = 1'b0;
        rxd         = 8'($urandom);
        repeat (low) tick();
    endtask

    task automatic check_all(input string tag, input bit with_stats);
        #1;
        chk(tag, "cmd_valid_pulses", vcnt, m_vcnt);
        chk(tag, "frame_err_pulses", ecnt, m_ecnt);
        chk(tag, "cmd", cmd, m_cmd);
        chk(tag, "cmd_len", cmd_len, m_len);
        chk(tag, "err_code", err_code, m_code);
        chk(tag, "busy", busy, m_active);
`ifdef PARSER_STATS_EN
        if (with_stats) begin
            chk(tag, "good_cnt", good_cnt, m_good);
            chk(tag, "bad_cnt", bad_cnt, m_bad);
        end
`endif
    endtask

    task automatic check_buf(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            #1;
            chk(tag, $sformatf("rd_data[%0d]", a), rd_data, (a < MAXL) ? m_buf[a] : 8'h00);
        end
    endtask

    task automatic set_vec(input int i, input logic [63:0] b, input int n, input int hold,
                           input int dv, input int de, input logic [1:0] code,
                           input logic [7:0] c, input logic [7:0] l);
        vecs[i].b    = b;
        vecs[i].n    = n;
        vecs[i].hold = hold;
        vecs[i].dv   = dv;
        vecs[i].de   = de;
        vecs[i].code = code;
        vecs[i].cmd  = c;
        vecs[i].len  = l;
    endtask

    task automatic send_r(input logic [7:0] b);
        if ($urandom % 10 == 0) repeat (T - 3 + int'($urandom_range(0, 6))) tick();
        send_byte(b, 1 + int'($urandom % 3), 1 + int'($urandom % 2));
        check_all("rand", 1'b1);
    endtask

    initial begin
        #(50_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pv, pe, kind, len;
        logic [7:0] fr [$];
        logic [7:0] x;

        set_vec(0, 64'h24_41_02_10_20_73_00_00, 6, 1, 1, 0, 2'd0, 8'h41, 8'h02);
        set_vec(1, 64'h24_41_02_10_20_74_00_00, 6, 1, 0, 1, 2'd1, 8'h41, 8'h02);
        set_vec(2, 64'h24_42_11_00_00_00_00_00, 3, 1, 0, 1, 2'd2, 8'h41, 8'h02);
        set_vec(3, 64'h24_42_00_42_00_00_00_00, 4, 2, 1, 0, 2'd0, 8'h42, 8'h00);
        set_vec(4, 64'h55_AA_24_43_01_7F_3D_00, 7, 5, 1, 0, 2'd0, 8'h43, 8'h01);

        m_vcnt = 0;
        m_ecnt = 0;
        model_reset();
        RST_n       = 1'b1;
        RECEIVE_END = 1'b0;
        rxd         = 8'h00;
        rd_addr     = 4'd0;
        #10 RST_n   = 1'b0;
        repeat (3) @(negedge iCLK);
        check_all("reset", 1'b1);
        check_buf("reset");
        @(negedge iCLK);
        RST_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            pv = vcnt;
            pe = ecnt;
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j], vecs[i].hold, 1);
            #1;
            chk($sformatf("vec%0d", i), "valid_inc", vcnt - pv, vecs[i].dv);
            chk($sformatf("vec%0d", i), "err_inc", ecnt - pe, vecs[i].de);
            chk($sformatf("vec%0d", i), "err_code_tbl", err_code, vecs[i].code);
            chk($sformatf("vec%0d", i), "cmd_tbl", cmd, vecs[i].cmd);
            chk($sformatf("vec%0d", i), "cmd_len_tbl", cmd_len, vecs[i].len);
            chk($sformatf("vec%0d", i), "busy_tbl", busy, 1'b0);
            check_all($sformatf("vec%0d", i), 1'b1);
            check_buf($sformatf("vec%0d", i));
        end

        // Inter-byte timeout: quiet through the limit, error on the expiry cycle.
        pe = ecnt;
        send_byte(8'h24, 1, 1);
        send_byte(8'h41, 1, 1);
        while (since < T + 1) tick();
        #1 chk("tmo", "no_err_before", ecnt - pe, 0);
        tick();
        check_all("tmo", 1'b0);
        chk("tmo", "err_code_3", err_code, 2'd3);
        repeat (2) tick();
        check_all("tmo_after", 1'b1);

        // A byte on the expiry cycle keeps the frame alive.
        pe = ecnt;
        pv = vcnt;
        send_byte(8'h24, 1, 1);
        send_byte(8'h41, 1, 1);
        while (since < T + 1) tick();
        send_byte(8'h00, 1, 1);
        send_byte(8'h41, 1, 1);
        #1;
        chk("edge", "no_err", ecnt - pe, 0);
        chk("edge", "valid_inc", vcnt - pv, 1);
        chk("edge", "err_code_0", err_code, 2'd0);
        check_all("edge", 1'b1);

        // Asynchronous reset mid-frame.
        send_byte(8'h24, 1, 1);
        send_byte(8'h41, 1, 1);
        #10 RST_n = 1'b0;
        model_reset();
        check_all("rst_mid", 1'b1);
        check_buf("rst_mid");
        @(negedge iCLK);
        RST_n = 1'b1;
        tick();
        pv = vcnt;
        send_byte(8'h24, 1, 1);
        send_byte(8'h44, 1, 1);
        send_byte(8'h00, 1, 1);
        send_byte(8'h44, 1, 1);
        tick();
        #1;
        chk("post_rst", "valid_inc", vcnt - pv, 1);
        chk("post_rst", "cmd_44", cmd, 8'h44);
`ifdef PARSER_STATS_EN
        chk("post_rst", "good_1", good_cnt, 16'd1);
        chk("post_rst", "bad_0", bad_cnt, 16'd0);
`endif
        check_all("post_rst", 1'b1);

        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom % 4);
            fr.delete();
            if (kind == 0) begin
                repeat (1 + int'($urandom % 3)) fr.push_back(8'($urandom));
            end else begin
                fr.push_back(START);
                fr.push_back(8'($urandom));
                if (kind == 3) begin
                    fr.push_back(8'(MAXL + 1 + int'($urandom % (255 - MAXL))));
                end else begin
                    len = int'($urandom % (MAXL + 1));
                    fr.push_back(8'(len));
                    x = fr[1] ^ fr[2];
                    for (int k = 0; k < len; k++) begin
                        fr.push_back(8'($urandom));
                        x = x ^ fr[fr.size() - 1];
                    end
                    if (kind == 2) x = x ^ 8'(1 + int'($urandom % 255));
                    fr.push_back(x);
                end
            end
            foreach (fr[k]) send_r(fr[k]);
            check_buf("rand_buf");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART receiver's byte stream (rxd, RECEIVE_END).
- Assembles bytes into framed commands: START, CMD, LEN, payload[LEN], CHK.
- Checks the XOR checksum, the length bound and the inter-byte timeout.
- Presents validated commands to mode/LED control logic as a one-cycle strobe plus held command fields and a readable payload buffer.

Parameters:
- START_BYTE, 8'h24: frame start marker ('$').
- MAX_LEN, 8: maximum payload bytes accepted, range 1..16.
- TIMEOUT_CYC, 20000: iCLK cycles allowed between bytes inside a frame.

Ports:
- iCLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- rxd  in  8  received byte; valid while RECEIVE_END is high.
- RECEIVE_END  in  1  byte-done flag from the receiver; level-tolerant.
- rd_addr  in  4  payload buffer read index.
- rd_data  out  8  payload byte at rd_addr; combinational read.
- cmd_valid  out  1  one-cycle strobe: a good frame has completed.
- cmd  out  8  CMD byte of the last good frame.
- cmd_len  out  8  LEN of the last good frame.
- frame_err  out  1  one-cycle strobe: a frame was discarded.
- err_code  out  2  last error: 0 none, 1 checksum, 2 length, 3 timeout.
- busy  out  1  high whenever the FSM state is not IDLE.

Behaviour:
- Reset values: cmd_valid=0, frame_err=0, cmd=0, cmd_len=0, err_code=0, busy=0, FSM=IDLE, payload buffer cleared to 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no strobe.
- Byte strobe: byte_stb = RECEIVE_END & ~RECEIVE_END_q, where RECEIVE_END_q is RECEIVE_END registered once. A long-high RECEIVE_END yields exactly one byte.
- FSM states: IDLE, CMD, LEN, DATA, CHK.
  - IDLE: on byte_stb with rxd==START_BYTE go to CMD. All other bytes are ignored silently.
  - CMD: on byte_stb latch cmd_tmp=rxd, set chk=rxd, go to LEN.
  - LEN, on byte_stb:
    - If rxd > MAX_LEN: pulse frame_err, err_code=2, go to IDLE.
    - Otherwise: latch len_tmp, chk ^= rxd, idx=0.
    - Next state is CHK if rxd==0, else DATA.
  - DATA: on byte_stb write buf[idx]=rxd, chk ^= rxd, idx++. When idx reaches len_tmp-1 (last byte) go to CHK.
  - CHK, on byte_stb:
    - If rxd==chk: cmd<=cmd_tmp, cmd_len<=len_tmp, err_code<=0, pulse cmd_valid. Go to IDLE.
    - Otherwise: pulse frame_err, err_code=1. Go to IDLE.
- START_BYTE appearing inside a frame is treated as ordinary data; there is no mid-frame resync.
- Latency: cmd_valid and frame_err go high in the cycle after the byte_stb cycle that decides them, for exactly one cycle.
- Payload buffer:
  - Written in place during reception; it is not double-buffered.
  - Contents are valid for the good frame from its cmd_valid until the first payload byte of the next frame.
  - rd_addr >= MAX_LEN reads 0.
- cmd, cmd_len and err_code hold their values between events.
- Timeout:
  - A counter clears on every byte_stb and in IDLE, and increments each cycle in the other states.
  - When it reaches TIMEOUT_CYC: pulse frame_err, err_code=3, go to IDLE.
  - If byte_stb occurs in the same cycle as expiry, the byte wins and the counter restarts.
- Counter width: $clog2(TIMEOUT_CYC+1).
- busy = (state != IDLE), registered state decode.

Optional Feature:
- Macro: PARSER_STATS_EN.
- Defined: adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - good_cnt increments on each cmd_valid; bad_cnt increments on each frame_err.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Bytes 24 41 02 10 20 73 -> cmd_valid pulse once; cmd=41, cmd_len=2; rd_data at addr0=10, addr1=20; err_code=0.
- Bytes 24 41 02 10 20 74 -> frame_err pulse, err_code=1; cmd/cmd_len keep their prior values; no cmd_valid.
- Bytes 24 42 11 (LEN 17 > 8) -> frame_err, err_code=2, busy=0. A following 24 42 00 42 gives cmd_valid with cmd=42, cmd_len=0.
- Bytes 24 41, then idle TIMEOUT_CYC cycles -> frame_err, err_code=3. A byte arriving exactly on the expiry cycle gives no error.
- Noise bytes 55 AA before 24 43 01 7F 3D -> noise ignored; cmd_valid with cmd=43, buf[0]=7F. RECEIVE_END held high 5 cycles counts as a single byte.
- RST_n pulsed low after 24 41 -> all outputs return to reset values immediately. Then 24 44 00 44 -> cmd_valid with cmd=44. With PARSER_STATS_EN: good_cnt=1, bad_cnt=0 after this.
